watch_digit_merge: RTL and testbench

- Inverse of the watch's binary-to-BCD digit separator.
- Accepts a two-digit BCD entry (tens, then ones) from the time-set button/keypad logic, one digit per handshake.
- Validates each digit and the merged value against a range limit, then outputs the 7-bit binary NUMBER consumed by the hour/minute/second counters.
- Sits between the set-mode input controller and the time registers.

---
 rtl/watch_digit_merge.sv | 176 +++++++++++++++++
 tb/tb_watch_digit_merge.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/watch_digit_merge.sv
// Merges a two-digit BCD entry (tens, then ones) into a 7-bit binary value with range checking.
// Optional inter-digit timeout is enabled by defining WATCH_MERGE_TIMEOUT_EN.
module watch_digit_merge #(
    parameter int MAX_VAL        = 59,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       CANCEL,
    input  logic [3:0] DIGIT_IN,
    input  logic       DIGIT_VALID,
    output logic [6:0] NUMBER,
    output logic       NUMBER_VALID,
    output logic       ERR,
    output logic       BUSY,
    output logic [3:0] ENTRY_A,
    output logic [3:0] ENTRY_B
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TENS = 2'd1,
        S_ONES = 2'd2,
        S_CALC = 2'd3
    } state_t;

    // Limits above 99 behave as 99, which every two-digit value already satisfies.
    localparam int         LIMIT   = (MAX_VAL > 99) ? 99 : MAX_VAL;
    localparam logic [6:0] LIMIT_V = 7'(LIMIT);

    if (TIMEOUT_CYCLES < 1 || MAX_VAL < 0) begin : g_bad_param
        $error("watch_digit_merge: TIMEOUT_CYCLES must be >= 1 and MAX_VAL >= 0");
    end

    function automatic logic [6:0] bcd_merge(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t7;
        t7 = {3'b000, tens};
        return (t7 << 3) + (t7 << 1) + {3'b000, ones};
    endfunction

    function automatic logic digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

    state_t     state_q, state_d;
    logic [6:0] number_q, number_d;
    logic       nv_q, nv_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [6:0] merged;
    logic       timeout_w;

`ifdef WATCH_MERGE_TIMEOUT_EN
    localparam int                 CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;

    assign waiting   = (state_q == S_TENS) || (state_q == S_ONES);
    assign timeout_w = waiting && !CANCEL && !DIGIT_VALID && (cnt_q == TO_LAST);

    // Counter restarts whenever the FSM leaves a waiting state or accepts a digit.
    always_comb begin
        cnt_d = '0;
        if (waiting && !CANCEL && !DIGIT_VALID && !timeout_w) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`else
    assign timeout_w = 1'b0;
`endif

    assign merged = bcd_merge(a_q, b_q);

    always_comb begin
        state_d  = state_q;
        number_d = number_q;
        nv_d     = 1'b0;
        err_d    = 1'b0;
        a_d      = a_q;
        b_d      = b_q;

        case (state_q)
            S_IDLE: begin
                if (START && !CANCEL) begin
                    state_d = S_TENS;
                    a_d     = 4'd0;
                    b_d     = 4'd0;
                end
            end
            S_TENS: begin
                if (CANCEL) begin
                    state_d = S_IDLE;
                end else if (DIGIT_VALID) begin
                    if (digit_ok(DIGIT_IN)) begin
                        a_d     = DIGIT_IN;
                        state_d = S_ONES;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (timeout_w) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ONES: begin
                if (CANCEL) begin
                    state_d = S_IDLE;
                end else if (DIGIT_VALID) begin
                    if (digit_ok(DIGIT_IN)) begin
                        b_d     = DIGIT_IN;
                        state_d = S_CALC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (timeout_w) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                state_d = S_IDLE;
                if (!CANCEL) begin
                    if (merged <= LIMIT_V) begin
                        number_d = merged;
                        nv_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            number_q <= 7'd0;
            nv_q     <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
`ifdef WATCH_MERGE_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            number_q <= number_d;
            nv_q     <= nv_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            a_q      <= a_d;
            b_q      <= b_d;
`ifdef WATCH_MERGE_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign NUMBER       = number_q;
    assign NUMBER_VALID = nv_q;
    assign ERR          = err_q;
    assign BUSY         = busy_q;
    assign ENTRY_A      = a_q;
    assign ENTRY_B      = b_q;

endmodule

// File: tb/tb_watch_digit_merge.sv
// Directed bench for watch_digit_merge: per-cycle vector table plus hand sequences for MAX_VAL=23 and timeout.
module tb_watch_digit_merge;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       CANCEL = 1'b0;
    logic [3:0] DIGIT_IN = 4'd0;
    logic       DIGIT_VALID = 1'b0;

    logic [6:0] num59, num23;
    logic       nv59, nv23, err59, err23, busy59, busy23;
    logic [3:0] a59, a23, b59, b23;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    watch_digit_merge #(.MAX_VAL(59), .TIMEOUT_CYCLES(8)) u59 (
        .CLK(CLK), .RST(RST), .START(START), .CANCEL(CANCEL),
        .DIGIT_IN(DIGIT_IN), .DIGIT_VALID(DIGIT_VALID),
        .NUMBER(num59), .NUMBER_VALID(nv59), .ERR(err59), .BUSY(busy59),
        .ENTRY_A(a59), .ENTRY_B(b59)
    );

    watch_digit_merge #(.MAX_VAL(23), .TIMEOUT_CYCLES(8)) u23 (
        .CLK(CLK), .RST(RST), .START(START), .CANCEL(CANCEL),
        .DIGIT_IN(DIGIT_IN), .DIGIT_VALID(DIGIT_VALID),
        .NUMBER(num23), .NUMBER_VALID(nv23), .ERR(err23), .BUSY(busy23),
        .ENTRY_A(a23), .ENTRY_B(b23)
    );

    typedef struct {
        logic       rst, start, cancel, dv;
        logic [3:0] d;
        logic [6:0] num;
        logic       nv, err, busy;
        logic [3:0] a, b;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic rst, input logic start, input logic cancel,
                                input logic dv, input logic [3:0] d, input logic [6:0] num,
                                input logic nv, input logic err, input logic busy,
                                input logic [3:0] a, input logic [3:0] b);
        vec_t v;
        v.rst = rst; v.start = start; v.cancel = cancel; v.dv = dv; v.d = d;
        v.num = num; v.nv = nv; v.err = err; v.busy = busy; v.a = a; v.b = b;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic c, input logic v, input logic [3:0] d);
        RST = r; START = s; CANCEL = c; DIGIT_VALID = v; DIGIT_IN = d;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //           rst start cancel dv  d     num   nv err busy a  b
        tv.push_back(mk(1, 0, 0, 0, 4'd0, 7'd0,  0, 0, 0, 4'd0, 4'd0)); // reset
        tv.push_back(mk(0, 0, 0, 0, 4'd0, 7'd0,  0, 0, 0, 4'd0, 4'd0));
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd0,  0, 0, 1, 4'd0, 4'd0)); // 4,7 -> 47
        tv.push_back(mk(0, 0, 0, 1, 4'd4, 7'd0,  0, 0, 1, 4'd4, 4'd0));
        tv.push_back(mk(0, 0, 0, 1, 4'd7, 7'd0,  0, 0, 1, 4'd4, 4'd7));
        tv.push_back(mk(0, 0, 0, 0, 4'd0, 7'd47, 1, 0, 0, 4'd4, 4'd7));
        tv.push_back(mk(0, 0, 0, 0, 4'd0, 7'd47, 0, 0, 0, 4'd4, 4'd7));
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd47, 0, 0, 1, 4'd0, 4'd0)); // 6,0 -> 60 rejected
        tv.push_back(mk(0, 0, 0, 1, 4'd6, 7'd47, 0, 0, 1, 4'd6, 4'd0));
        tv.push_back(mk(0, 0, 0, 1, 4'd0, 7'd47, 0, 0, 1, 4'd6, 4'd0));
        tv.push_back(mk(0, 0, 0, 0, 4'd0, 7'd47, 0, 1, 0, 4'd6, 4'd0));
        tv.push_back(mk(0, 0, 0, 0, 4'd0, 7'd47, 0, 0, 0, 4'd6, 4'd0));
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd47, 0, 0, 1, 4'd0, 4'd0)); // bad tens digit
        tv.push_back(mk(0, 0, 0, 1, 4'hA, 7'd47, 0, 1, 0, 4'd0, 4'd0));
        tv.push_back(mk(0, 0, 0, 1, 4'd5, 7'd47, 0, 0, 0, 4'd0, 4'd0)); // digit in IDLE ignored
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd47, 0, 0, 1, 4'd0, 4'd0));
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd47, 0, 0, 1, 4'd0, 4'd0)); // START while busy
        tv.push_back(mk(0, 0, 0, 1, 4'd3, 7'd47, 0, 0, 1, 4'd3, 4'd0));
        tv.push_back(mk(0, 1, 0, 1, 4'd2, 7'd47, 0, 0, 1, 4'd3, 4'd2));
        tv.push_back(mk(0, 0, 1, 0, 4'd0, 7'd47, 0, 0, 0, 4'd3, 4'd2)); // cancel in CALC
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd47, 0, 0, 1, 4'd0, 4'd0));
        tv.push_back(mk(0, 0, 0, 1, 4'd3, 7'd47, 0, 0, 1, 4'd3, 4'd0));
        tv.push_back(mk(0, 0, 1, 1, 4'd9, 7'd47, 0, 0, 0, 4'd3, 4'd0)); // cancel beats digit
        tv.push_back(mk(0, 0, 0, 0, 4'd0, 7'd47, 0, 0, 0, 4'd3, 4'd0));
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd47, 0, 0, 1, 4'd0, 4'd0)); // 0,0 -> 0
        tv.push_back(mk(0, 0, 0, 1, 4'd0, 7'd47, 0, 0, 1, 4'd0, 4'd0));
        tv.push_back(mk(0, 0, 0, 1, 4'd0, 7'd47, 0, 0, 1, 4'd0, 4'd0));
        tv.push_back(mk(0, 0, 0, 0, 4'd0, 7'd0,  1, 0, 0, 4'd0, 4'd0));
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd0,  0, 0, 1, 4'd0, 4'd0)); // 1,5 -> 15
        tv.push_back(mk(0, 0, 0, 1, 4'd1, 7'd0,  0, 0, 1, 4'd1, 4'd0));
        tv.push_back(mk(0, 0, 0, 1, 4'd5, 7'd0,  0, 0, 1, 4'd1, 4'd5));
        tv.push_back(mk(0, 0, 0, 0, 4'd0, 7'd15, 1, 0, 0, 4'd1, 4'd5));
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd15, 0, 0, 1, 4'd0, 4'd0)); // bad ones digit
        tv.push_back(mk(0, 0, 0, 1, 4'd2, 7'd15, 0, 0, 1, 4'd2, 4'd0));
        tv.push_back(mk(0, 0, 0, 1, 4'hB, 7'd15, 0, 1, 0, 4'd2, 4'd0));
        tv.push_back(mk(0, 1, 0, 0, 4'd0, 7'd15, 0, 0, 1, 4'd0, 4'd0)); // reset mid-entry
        tv.push_back(mk(0, 0, 0, 1, 4'd5, 7'd15, 0, 0, 1, 4'd5, 4'd0));
        tv.push_back(mk(1, 0, 0, 0, 4'd0, 7'd0,  0, 0, 0, 4'd0, 4'd0));
        tv.push_back(mk(0, 0, 0, 1, 4'd9, 7'd0,  0, 0, 0, 4'd0, 4'd0));
        tv.push_back(mk(0, 1, 1, 0, 4'd0, 7'd0,  0, 0, 0, 4'd0, 4'd0)); // START+CANCEL in IDLE
        tv.push_back(mk(0, 0, 0, 1, 4'd9, 7'd0,  0, 0, 0, 4'd0, 4'd0));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst, tv[i].start, tv[i].cancel, tv[i].dv, tv[i].d);
            chk($sformatf("v%0d NUMBER", i),       num59,  tv[i].num);
            chk($sformatf("v%0d NUMBER_VALID", i), nv59,   tv[i].nv);
            chk($sformatf("v%0d ERR", i),          err59,  tv[i].err);
            chk($sformatf("v%0d BUSY", i),         busy59, tv[i].busy);
            chk($sformatf("v%0d ENTRY_A", i),      a59,    tv[i].a);
            chk($sformatf("v%0d ENTRY_B", i),      b59,    tv[i].b);
        end

        // Hour-range instance: 23 accepted, 24 rejected while the 59 instance accepts it.
        step(0, 1, 0, 0, 4'd0);
        step(0, 0, 0, 1, 4'd2);
        step(0, 0, 0, 1, 4'd3);
        step(0, 0, 0, 0, 4'd0);
        chk("h23 NUMBER", num23, 23);
        chk("h23 NUMBER_VALID", nv23, 1);
        chk("h23 ERR", err23, 0);
        chk("h23 NUMBER m59", num59, 23);
        step(0, 1, 0, 0, 4'd0);
        step(0, 0, 0, 1, 4'd2);
        step(0, 0, 0, 1, 4'd4);
        step(0, 0, 0, 0, 4'd0);
        chk("h24 ERR", err23, 1);
        chk("h24 NUMBER_VALID", nv23, 0);
        chk("h24 NUMBER held", num23, 23);
        chk("h24 NUMBER m59", num59, 24);
        chk("h24 NUMBER_VALID m59", nv59, 1);
        step(0, 0, 0, 0, 4'd0);
        chk("h24 ERR pulse width", err23, 0);

        // Idle wait after START: times out after 8 cycles only when the feature is built in.
        step(0, 1, 0, 0, 4'd0);
        chk("to BUSY start", busy59, 1);
`ifdef WATCH_MERGE_TIMEOUT_EN
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 0, 0, 4'd0);
            chk($sformatf("to ERR early c%0d", i), err59, 0);
            chk($sformatf("to BUSY early c%0d", i), busy59, 1);
        end
        step(0, 0, 0, 0, 4'd0);
        chk("to ERR fire", err59, 1);
        chk("to BUSY after", busy59, 0);
        step(0, 0, 0, 0, 4'd0);
        chk("to ERR pulse width", err59, 0);
`else
        begin
            int err_seen;
            int busy_low;
            err_seen = 0;
            busy_low = 0;
            for (int i = 0; i < 60; i++) begin
                step(0, 0, 0, 0, 4'd0);
                if (err59) err_seen++;
                if (!busy59) busy_low++;
            end
            chk("no-to ERR count", err_seen, 0);
            chk("no-to BUSY low count", busy_low, 0);
            step(0, 0, 1, 0, 4'd0);
            chk("no-to cancel BUSY", busy59, 0);
            chk("no-to cancel ERR", err59, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
